// File: rtl/register_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
package register_scoreboard_pkg;

    localparam int REGISTER_COUNT         = 32;
    localparam int REGISTER_ADDRESS_WIDTH = 5;

    typedef logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REGISTER = 5'd0;

endpackage

// File: rtl/scoreboard_entry.sv
// One per-register in-flight write counter with pending status and an underflow pulse.
module scoreboard_entry #(
    parameter int unsigned COUNT_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   inc,
    input  logic                   dec,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   pending,
    output logic                   underflow
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // A simultaneous increment and decrement cancel out, even from zero.
    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (count_q != CountMax) begin
                count_d = count_q + CountOne;
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - CountOne;
            end else begin
                underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign pending = (count_q != '0);

endmodule

// File: rtl/register_scoreboard.sv
// Tracks in-flight register writes from issue to writeback and gates issue on RAW hazards.
// Optional SCOREBOARD_BYPASS_EN hides a hazard whose last write retires this cycle.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              issue_valid,
    input  logic                              issue_writes,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_dest,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] source_a,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] source_b,
    output logic                              issue_ready,
    output logic                              hazard_a,
    output logic                              hazard_b,
    input  logic                              writeback_valid,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] writeback_dest,
    output logic                              underflow_error
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

    logic [COUNT_WIDTH-1:0]    counts [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] pending;
    logic [REGISTER_COUNT-1:0] inc;
    logic [REGISTER_COUNT-1:0] dec;
    logic [REGISTER_COUNT-1:0] underflow;
    logic                      issue_fire;
    logic                      at_max;
    logic                      underflow_error_q;

    // $r0 has no entry: it is never pending and ignores issues and writebacks.
    assign counts[0]    = '0;
    assign pending[0]   = 1'b0;
    assign inc[0]       = 1'b0;
    assign dec[0]       = 1'b0;
    assign underflow[0] = 1'b0;

    assign issue_fire = issue_valid && issue_ready;

    for (genvar r = 1; r < REGISTER_COUNT; r++) begin : g_entry
        localparam reg_addr_t Addr = reg_addr_t'(r);

        assign inc[r] = issue_fire && issue_writes && (issue_dest == Addr);
        assign dec[r] = writeback_valid && (writeback_dest == Addr);

        scoreboard_entry #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_entry (
            .clock     (clock),
            .reset_n   (reset_n),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .count     (counts[r]),
            .pending   (pending[r]),
            .underflow (underflow[r])
        );
    end

`ifdef SCOREBOARD_BYPASS_EN
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    logic last_write_retiring;

    // The register file writes before it reads, so the retiring value is visible now.
    assign last_write_retiring = writeback_valid && (writeback_dest != ZERO_REGISTER)
                                 && (counts[writeback_dest] == CountOne);

    assign hazard_a = pending[source_a] && !(last_write_retiring && (source_a == writeback_dest));
    assign hazard_b = pending[source_b] && !(last_write_retiring && (source_b == writeback_dest));
`else
    assign hazard_a = pending[source_a];
    assign hazard_b = pending[source_b];
`endif

    assign at_max      = issue_writes && (counts[issue_dest] == CountMax);
    assign issue_ready = !hazard_a && !hazard_b && !at_max;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow_error_q <= 1'b0;
        end else if (|underflow) begin
            underflow_error_q <= 1'b1;
        end
    end

    assign underflow_error = underflow_error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard (COUNT_WIDTH = 2).
module tb_register_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       issue_valid;
    logic       issue_writes;
    logic [4:0] issue_dest;
    logic [4:0] source_a;
    logic [4:0] source_b;
    logic       issue_ready;
    logic       hazard_a;
    logic       hazard_b;
    logic       writeback_valid;
    logic [4:0] writeback_dest;
    logic       underflow_error;

    int total = 0;
    int bad   = 0;

    register_scoreboard #(
        .COUNT_WIDTH (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .issue_valid     (issue_valid),
        .issue_writes    (issue_writes),
        .issue_dest      (issue_dest),
        .source_a        (source_a),
        .source_b        (source_b),
        .issue_ready     (issue_ready),
        .hazard_a        (hazard_a),
        .hazard_b        (hazard_b),
        .writeback_valid (writeback_valid),
        .writeback_dest  (writeback_dest),
        .underflow_error (underflow_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Inputs change 2 units after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input logic [4:0] dest);
        issue_valid  = 1'b1;
        issue_writes = 1'b1;
        issue_dest   = dest;
    endtask

    task automatic idle();
        issue_valid     = 1'b0;
        issue_writes    = 1'b0;
        issue_dest      = '0;
        writeback_valid = 1'b0;
        writeback_dest  = '0;
    endtask

    initial begin
        reset_n  = 1'b0;
        source_a = '0;
        source_b = '0;
        idle();
        tick();
        tick();
        #1;
        check("reset_hazard_a", hazard_a, 1'b0);
        check("reset_hazard_b", hazard_b, 1'b0);
        check("reset_ready", issue_ready, 1'b1);
        check("reset_underflow", underflow_error, 1'b0);
        reset_n = 1'b1;
        tick();

        // Clean sources.
        source_a = 5'd3;
        source_b = 5'd4;
        #1;
        check("clean_hazard_a", hazard_a, 1'b0);
        check("clean_hazard_b", hazard_b, 1'b0);
        check("clean_ready", issue_ready, 1'b1);

        // Basic RAW hazard on $5.
        source_a = '0;
        source_b = '0;
        issue(5'd5);
        #1;
        check("r5_issue_ready", issue_ready, 1'b1);
        tick();
        idle();
        source_a = 5'd5;
        #1;
        check("r5_hazard", hazard_a, 1'b1);
        check("r5_stall", issue_ready, 1'b0);
        writeback_valid = 1'b1;
        writeback_dest  = 5'd5;
        #1;
        check("r5_wb_same_cycle", hazard_a, !Byp);
        check("r5_wb_ready", issue_ready, Byp);
        tick();
        idle();
        #1;
        check("r5_cleared", hazard_a, 1'b0);
        check("r5_ready_after", issue_ready, 1'b1);

        // Saturation on $7.
        source_a = '0;
        for (int i = 0; i < 3; i++) begin
            issue(5'd7);
            #1;
            check("r7_fill_ready", issue_ready, 1'b1);
            tick();
        end
        issue(5'd7);
        #1;
        check("r7_saturated", issue_ready, 1'b0);
        tick();
        #1;
        check("r7_still_saturated", issue_ready, 1'b0);
        idle();
        #1;
        check("r7_no_write_ready", issue_ready, 1'b1);
        source_b = 5'd7;
        #1;
        check("r7_hazard_b", hazard_b, 1'b1);
        source_b = '0;

        // Simultaneous issue and writeback on $9 keeps count at 1.
        issue(5'd9);
        tick();
        issue(5'd9);
        writeback_valid = 1'b1;
        writeback_dest  = 5'd9;
        #1;
        check("r9_both_ready", issue_ready, 1'b1);
        tick();
        idle();
        source_a = 5'd9;
        #1;
        check("r9_pending", hazard_a, 1'b1);
        writeback_valid = 1'b1;
        writeback_dest  = 5'd9;
        #1;
        check("r9_wb_same_cycle", hazard_a, !Byp);
        tick();
        idle();
        #1;
        check("r9_cleared", hazard_a, 1'b0);
        check("r9_no_underflow", underflow_error, 1'b0);

        // $r0 is never pending and a writeback to it is harmless.
        source_a = '0;
        issue(5'd0);
        #1;
        check("r0_issue_ready", issue_ready, 1'b1);
        tick();
        idle();
        #1;
        check("r0_no_hazard", hazard_a, 1'b0);
        writeback_valid = 1'b1;
        writeback_dest  = 5'd0;
        tick();
        idle();
        #1;
        check("r0_wb_no_underflow", underflow_error, 1'b0);

        // Underflow on $12 is sticky.
        writeback_valid = 1'b1;
        writeback_dest  = 5'd12;
        #1;
        check("r12_not_yet", underflow_error, 1'b0);
        tick();
        idle();
        #1;
        check("r12_underflow", underflow_error, 1'b1);
        tick();
        tick();
        #1;
        check("r12_sticky", underflow_error, 1'b1);

        // Mid-stream reset clears everything at once.
        issue(5'd2);
        tick();
        issue(5'd3);
        tick();
        idle();
        source_a = 5'd2;
        source_b = 5'd3;
        #1;
        check("pend_hazard_a", hazard_a, 1'b1);
        check("pend_hazard_b", hazard_b, 1'b1);
        check("pend_stall", issue_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_hazard_a", hazard_a, 1'b0);
        check("rst_hazard_b", hazard_b, 1'b0);
        check("rst_ready", issue_ready, 1'b1);
        check("rst_underflow", underflow_error, 1'b0);
        tick();
        reset_n  = 1'b1;
        source_a = 5'd7;
        source_b = '0;
        #1;
        check("rst_r7_cleared", hazard_a, 1'b0);
        tick();
        writeback_valid = 1'b1;
        writeback_dest  = 5'd2;
        tick();
        idle();
        #1;
        check("rst_late_wb_underflow", underflow_error, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
